dmem_axi_responder: RTL and testbench

- Memory-side responder for the data-cache AXI-style master port. It answers read bursts (AR/R) and write bursts (AW/W/B) from one word-addressed on-chip RAM.
- Used as the memory model and bridge behind the D-cache in simulation and FPGA bring-up.
- The master has no rready and no bready. Every R beat and the B pulse are therefore fire-and-forget.
- One transaction in flight at a time.

---
 rtl/dmem_axi_pkg.sv | 15 +
 rtl/dmem_axi_responder_if.sv | 40 ++++
 rtl/dmem_ram_1rw.sv | 29 ++
 rtl/dmem_axi_responder.sv | 175 +++++++++++++++++
 tb/tb_dmem_axi_responder.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_axi_pkg.sv
// Shared types and widths for the data-memory AXI-style responder.
package dmem_axi_pkg;

    localparam int unsigned LEN_W  = 4;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_WAIT  = 3'd1,
        RD_BURST = 3'd2,
        WR_DATA  = 3'd3,
        WR_RESP  = 3'd4
    } state_t;

endpackage

// File: rtl/dmem_axi_responder_if.sv
// D-cache master port bundle: AR/R read channel, AW/W/B write channel, sticky error.
// The master has no rready/bready, so R beats and the B pulse are fire-and-forget.
interface dmem_axi_responder_if;
    import dmem_axi_pkg::*;

    logic [31:0]       araddr;
    logic [LEN_W-1:0]  arlen;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              rlast;

    logic [31:0]       awaddr;
    logic [LEN_W-1:0]  awlen;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic              wvalid;
    logic              wlast;
    logic              wready;
    logic              bvalid;

    logic              err;

    modport master (
        output araddr, arlen, arvalid,
        input  arready, rdata, rvalid, rlast,
        output awaddr, awlen, awvalid, wdata, wvalid, wlast,
        input  awready, wready, bvalid, err
    );

    modport slave (
        input  araddr, arlen, arvalid,
        output arready, rdata, rvalid, rlast,
        input  awaddr, awlen, awvalid, wdata, wvalid, wlast,
        output awready, wready, bvalid, err
    );

endinterface

// File: rtl/dmem_ram_1rw.sv
// Word-addressed RAM: one synchronous write port, one registered read port.
// Contents are never cleared; a read of the word being written returns the old value.
module dmem_ram_1rw #(
    parameter int unsigned AW = 12,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1 << AW) - 1];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port: data appears the cycle after raddr is presented.
    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/dmem_axi_responder.sv
// Memory-side responder for the D-cache master port: serves INCR read bursts
// and write bursts from one on-chip RAM, one transaction at a time.
module dmem_axi_responder
    import dmem_axi_pkg::*;
#(
    parameter int unsigned MEM_AW = 12,
    parameter int unsigned RD_LAT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    dmem_axi_responder_if.slave  bus
);

    // RD_WAIT lasts RD_LAT-1 cycles; the counter runs down to zero.
    localparam logic [3:0] WAIT_INIT = (RD_LAT >= 2) ? 4'(RD_LAT - 2) : 4'd0;

    state_t              state;
    logic [MEM_AW-1:0]   addr;
    logic [LEN_W-1:0]    len;
    logic [LEN_W-1:0]    beat;
    logic [3:0]          wait_cnt;
    logic                rvalid_q;
    logic                rlast_q;
    logic                wready_q;
    logic                bvalid_q;
    logic                err_q;

    logic                ar_fire;
    logic                aw_fire;
    logic                w_fire;
    logic                w_end_cnt;
    logic [MEM_AW-1:0]   ar_word;
    logic [MEM_AW-1:0]   aw_word;
    logic [MEM_AW-1:0]   addr_inc;
    logic [LEN_W-1:0]    beat_inc;
    logic [MEM_AW-1:0]   ram_raddr;
    logic [DATA_W-1:0]   ram_q;
    logic                unused_addr_bits;

    assign ar_word   = bus.araddr[MEM_AW+1:2];
    assign aw_word   = bus.awaddr[MEM_AW+1:2];
    assign addr_inc  = addr + MEM_AW'(1);
    assign beat_inc  = beat + LEN_W'(1);

    // Byte offset and address bits above the RAM are ignored.
    assign unused_addr_bits = ^{bus.araddr[31:MEM_AW+2], bus.araddr[1:0],
                                bus.awaddr[31:MEM_AW+2], bus.awaddr[1:0]};

    // Reads win a simultaneous request; both readies are live only in IDLE.
    assign ar_fire = (state == IDLE) && bus.arvalid && !reset;
    assign aw_fire = (state == IDLE) && bus.awvalid && !bus.arvalid && !reset;
    assign w_fire  = (state == WR_DATA) && bus.wvalid && !reset;
    assign w_end_cnt = (beat == len);

    assign bus.arready = ar_fire;
    assign bus.awready = aw_fire;
    assign bus.rvalid  = rvalid_q;
    assign bus.rlast   = rlast_q;
    assign bus.rdata   = rvalid_q ? ram_q : '0;
    assign bus.wready  = wready_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.err     = err_q;

    // Read address runs one word ahead of the beat being presented, because the
    // RAM output is registered: the handshake cycle (or last wait cycle) fetches
    // the first word, and each burst beat fetches the following one.
    always_comb begin
        ram_raddr = addr;
        if (state == IDLE) begin
            ram_raddr = ar_word;
        end else if (state == RD_BURST) begin
            ram_raddr = addr_inc;
        end
    end

    dmem_ram_1rw #(
        .AW (MEM_AW),
        .DW (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (w_fire),
        .waddr (addr),
        .wdata (bus.wdata),
        .raddr (ram_raddr),
        .rdata (ram_q)
    );

    // Transaction FSM with registered handshake outputs, counters and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            addr     <= '0;
            len      <= '0;
            beat     <= '0;
            wait_cnt <= '0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            wready_q <= 1'b0;
            bvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ar_fire) begin
                        addr <= ar_word;
                        len  <= bus.arlen;
                        beat <= '0;
                        if (RD_LAT == 1) begin
                            state    <= RD_BURST;
                            rvalid_q <= 1'b1;
                            rlast_q  <= (bus.arlen == '0);
                        end else begin
                            state    <= RD_WAIT;
                            wait_cnt <= WAIT_INIT;
                        end
                    end else if (aw_fire) begin
                        addr     <= aw_word;
                        len      <= bus.awlen;
                        beat     <= '0;
                        wready_q <= 1'b1;
                        state    <= WR_DATA;
                    end
                end

                RD_WAIT: begin
                    if (wait_cnt == '0) begin
                        state    <= RD_BURST;
                        rvalid_q <= 1'b1;
                        rlast_q  <= (len == '0);
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                RD_BURST: begin
                    if (rlast_q) begin
                        state    <= IDLE;
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                    end else begin
                        addr    <= addr_inc;
                        beat    <= beat_inc;
                        rlast_q <= (beat_inc == len);
                    end
                end

                WR_DATA: begin
                    if (w_fire) begin
                        addr <= addr_inc;
                        beat <= beat_inc;
                        if (bus.wlast != w_end_cnt) begin
                            err_q <= 1'b1;
                        end
                        // Burst ends at whichever of wlast / beat count comes first.
                        if (bus.wlast || w_end_cnt) begin
                            state    <= WR_RESP;
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                        end
                    end
                end

                WR_RESP: begin
                    bvalid_q <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_axi_responder.sv
// Directed bench for dmem_axi_responder: a transaction-level model predicts
// every output each cycle, and literal expectations pin the model.
module tb_dmem_axi_responder;

    localparam int MEM_AW = 12;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 1 << MEM_AW;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    dmem_axi_responder_if bus ();

    dmem_axi_responder #(
        .MEM_AW (MEM_AW),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    // Model state: timeline of expected outputs keyed by cycle number.
    logic [31:0] mmem [DEPTH];
    bit          mw   [DEPTH];
    bit          exp_rv [int];
    bit          exp_rl [int];
    bit          exp_bv [int];
    logic [31:0] exp_rd [int];
    int          busy_until = -1;
    bit          wr_act = 1'b0;
    int          wr_from, wr_len, wr_cnt, wr_addr;
    bit          err_m = 1'b0;

    // Observations for the literal checks.
    logic [31:0] rq [$];
    int ar_cyc, aw_cyc, first_rv, rl_cyc, bv_cyc, wl_cyc;
    int rl_cnt = 0;
    int bv_cnt = 0;
    bit rv_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle compare against the model, then advance the model.
    always @(negedge clk) begin : cmp
        bit e_arr, e_awr, e_wr, idle, last_by_cnt;
        int base;
        idle  = (cyc > busy_until);
        e_arr = idle && bus.arvalid && !reset;
        e_awr = idle && bus.awvalid && !bus.arvalid && !reset;
        e_wr  = wr_act && (cyc >= wr_from);
        if (chk_en) begin
            chk("arready", bus.arready, e_arr);
            chk("awready", bus.awready, e_awr);
            chk("wready", bus.wready, e_wr);
            chk("rvalid", bus.rvalid, exp_rv.exists(cyc));
            chk("rlast", bus.rlast, exp_rl.exists(cyc));
            chk("bvalid", bus.bvalid, exp_bv.exists(cyc));
            chk("err", bus.err, err_m);
            if (exp_rv.exists(cyc) && exp_rd.exists(cyc))
                chk("rdata", bus.rdata, exp_rd[cyc]);
        end
        if (bus.rvalid) rq.push_back(bus.rdata);
        if (bus.rvalid && !rv_prev) first_rv = cyc;
        rv_prev = bus.rvalid;
        if (bus.rlast) begin rl_cnt++; rl_cyc = cyc; end
        if (bus.bvalid) begin bv_cnt++; bv_cyc = cyc; end
        if (bus.arvalid && bus.arready) ar_cyc = cyc;
        if (bus.awvalid && bus.awready) aw_cyc = cyc;
        if (bus.wvalid && bus.wready && bus.wlast) wl_cyc = cyc;

        if (reset) begin
            exp_rv.delete(); exp_rl.delete(); exp_bv.delete(); exp_rd.delete();
            busy_until = cyc;
            wr_act = 1'b0;
            err_m  = 1'b0;
        end else begin
            if (e_arr) begin
                base = int'(bus.araddr[13:2]);
                for (int k = 0; k <= int'(bus.arlen); k++) begin
                    exp_rv[cyc + RD_LAT + k] = 1'b1;
                    if (mw[(base + k) % DEPTH]) exp_rd[cyc + RD_LAT + k] = mmem[(base + k) % DEPTH];
                end
                exp_rl[cyc + RD_LAT + int'(bus.arlen)] = 1'b1;
                busy_until = cyc + RD_LAT + int'(bus.arlen);
            end else if (e_awr) begin
                busy_until = 1 << 30;
                wr_act  = 1'b1;
                wr_from = cyc + 1;
                wr_cnt  = 0;
                wr_len  = int'(bus.awlen);
                wr_addr = int'(bus.awaddr[13:2]);
            end
            if (e_wr && bus.wvalid) begin
                mmem[wr_addr] = bus.wdata;
                mw[wr_addr]   = 1'b1;
                last_by_cnt   = (wr_cnt == wr_len);
                if (bus.wlast != last_by_cnt) err_m = 1'b1;
                if (bus.wlast || last_by_cnt) begin
                    wr_act = 1'b0;
                    exp_bv[cyc + 1] = 1'b1;
                    busy_until = cyc + 1;
                end
                wr_addr = (wr_addr + 1) % DEPTH;
                wr_cnt++;
            end
        end
        cyc++;
    end

    task automatic wait_hs(input bit is_ar, input string name);
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (is_ar ? bus.arready : bus.awready) return;
        end
        checks++;
        errors++;
        $display("FAIL %s: handshake timeout, got ready=0 expected ready=1", name);
    endtask

    task automatic do_read(input logic [31:0] a, input int len);
        rq.delete();
        bus.araddr  = a;
        bus.arlen   = 4'(len);
        bus.arvalid = 1'b1;
        wait_hs(1'b1, "ar_hs");
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        repeat (RD_LAT + len) @(posedge clk);
        #1;
    endtask

    // Beat i carries d0+i; wlast on beat wl_beat; hold>0 keeps the final beat driven.
    task automatic do_write(input logic [31:0] a, input int len, input logic [31:0] d0,
                            input int nbeats, input int wl_beat, input int hold);
        bus.awaddr  = a;
        bus.awlen   = 4'(len);
        bus.awvalid = 1'b1;
        wait_hs(1'b0, "aw_hs");
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            bus.wvalid = 1'b1;
            bus.wdata  = d0 + 32'(i);
            bus.wlast  = (i == wl_beat);
            @(posedge clk); #1;
        end
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_rq(input string name, input logic [31:0] base, input int n);
        chk({name, "_beats"}, rq.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < rq.size()) chk(name, rq[i], base + 32'(i));
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int bv0;
        bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0;
        bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
        bus.wdata  = '0; bus.wvalid = 1'b0; bus.wlast = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_arready", bus.arready, 0);
        chk("rst_awready", bus.awready, 0);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_rlast", bus.rlast, 0);
        chk("rst_wready", bus.wready, 0);
        chk("rst_bvalid", bus.bvalid, 0);
        chk("rst_err", bus.err, 0);
        chk_en = 1'b1;
        @(posedge clk); #1;

        // Words 0..7 = 0x5000+i, words 0x40..0x4F = 0x1000+i.
        do_write(32'h0000_0000, 7, 32'h5000, 8, 7, 0);
        do_write(32'h0000_0100, 15, 32'h1000, 16, 15, 0);

        do_read(32'h0000_0100, 15);
        check_rq("rd_0x100", 32'h1000, 16);
        chk("rd_latency", first_rv - ar_cyc, RD_LAT);
        chk("rlast_beat16", rl_cyc - first_rv, 15);

        do_write(32'h0000_0200, 15, 32'hA0, 16, 15, 0);
        chk("b_after_last", bv_cyc - wl_cyc, 1);
        do_read(32'h0000_0200, 15);
        check_rq("rd_0x200", 32'hA0, 16);
        chk("err_clean", bus.err, 0);

        // Held wvalid/wlast past the response must not write a second word.
        bv0 = bv_cnt;
        do_write(32'hB000_0010, 0, 32'hDEADBEEF, 1, 0, 2);
        chk("hold_one_b", bv_cnt - bv0, 1);
        do_read(32'h0000_0010, 1);
        chk("hold_beats", rq.size(), 2);
        if (rq.size() == 2) begin
            chk("hold_word4", rq[0], 32'hDEADBEEF);
            chk("hold_word5", rq[1], 32'h5005);
        end

        // Simultaneous AR and AW: read first, AW accepted on return to IDLE.
        bus.awaddr = 32'h0000_0400; bus.awlen = 4'd0; bus.awvalid = 1'b1;
        rq.delete();
        bus.araddr = 32'h0000_0100; bus.arlen = 4'd3; bus.arvalid = 1'b1;
        wait_hs(1'b1, "sim_ar_hs");
        chk("sim_awready_low", bus.awready, 0);
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        do_write(32'h0000_0400, 0, 32'h99, 1, 0, 0);
        check_rq("sim_rd", 32'h1000, 4);
        chk("sim_aw_after_rd", aw_cyc - ar_cyc, RD_LAT + 3 + 1);
        do_read(32'h0000_0400, 0);
        check_rq("sim_wr", 32'h99, 1);

        // Wrap across the top of the RAM in both directions.
        do_write(32'h0000_3FFC, 3, 32'hC0DE0000, 4, 3, 0);
        do_read(32'h0000_3FFC, 3);
        check_rq("wrap_rd", 32'hC0DE0000, 4);

        // Early wlast: two writes, sticky error.
        do_write(32'h0000_0300, 3, 32'h77, 2, 1, 0);
        chk("err_set", bus.err, 1);
        do_read(32'h0000_0300, 1);
        check_rq("early_wlast_rd", 32'h77, 2);
        chk("err_sticky", bus.err, 1);

        // Reset in the middle of a read burst.
        rq.delete();
        bus.araddr = 32'h0000_0100; bus.arlen = 4'd15; bus.arvalid = 1'b1;
        wait_hs(1'b1, "rst_ar_hs");
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_rvalid", bus.rvalid, 0);
        chk("midrst_err", bus.err, 0);
        chk("midrst_arready_idle", bus.arready, 0);
        @(posedge clk); #1;

        do_read(32'h0000_0200, 1);
        check_rq("post_rst_rd", 32'hA0, 2);

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
